// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, NUM_DIGITS
// common-anode digits, blanking gap, frame-synchronous updates, zero blanking.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   enable            1 = scan, 0 = display dark
//   load              strobe: capture value/dp_mask into shadow registers
//   value, dp_mask    display nibbles (nibble k = digit k) and DP enables
//   hex_out, seg_in   nibble to / active-low segments from the shared decoder
//   seg_out, an_out   active-low segment and anode pins (seg_out[7] = DP)
//   frame_sync        pulse on the first blank cycle of digit 0
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 16,
  parameter int LZ_BLANK       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              hex_out,
  input  logic [7:0]              seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_sync
);

  localparam int CMAX =
    (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CW = $clog2(CMAX);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t            st;
  logic [DW-1:0]     dig;
  logic [CW-1:0]     cnt;
  logic [VW-1:0]     shd_val;
  logic [NUM_DIGITS-1:0] shd_dp;
  logic [VW-1:0]     act_val;
  logic [NUM_DIGITS-1:0] act_dp;
  logic              pend;

  state_t            st_nx;
  logic [DW-1:0]     dig_nx;
  logic [CW-1:0]     cnt_nx;
  logic [VW-1:0]     val_nx;
  logic [NUM_DIGITS-1:0] dp_nx;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] an_nx;
  logic [3:0]        nib_nx;
  logic              drive_nx;
  logic              bound_nx;

  // DP comes from the mask, never from the decoder
  logic seg_in_unused;
  assign seg_in_unused = seg_in[7];

  always_comb begin
    st_nx  = st;
    dig_nx = dig;
    cnt_nx = cnt + CW'(1);
    case (st)
      IDLE: begin
        cnt_nx = '0;
        dig_nx = '0;
        if (enable) st_nx = BLANK;
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CLKS - 1)) begin
          st_nx  = DRIVE;
          cnt_nx = '0;
        end
      end
      DRIVE: begin
        if (cnt == CW'(CLKS_PER_DIGIT - 1)) begin
          st_nx  = BLANK;
          cnt_nx = '0;
          if (dig == DW'(NUM_DIGITS - 1))
            dig_nx = '0;
          else
            dig_nx = dig + DW'(1);
        end
      end
      default: begin
        st_nx  = IDLE;
        cnt_nx = '0;
        dig_nx = '0;
      end
    endcase
    if (!enable) begin
      st_nx  = IDLE;
      cnt_nx = '0;
      dig_nx = '0;
    end
  end

  assign bound_nx = (st_nx == BLANK) && (dig_nx == '0)
                 && (cnt_nx == '0);

  // Active value only moves at the end of the frame_sync cycle
  always_comb begin
    val_nx = act_val;
    dp_nx  = act_dp;
    if (frame_sync) begin
      if (load) begin
        val_nx = value;
        dp_nx  = dp_mask;
      end else if (pend) begin
        val_nx = shd_val;
        dp_nx  = shd_dp;
      end
    end
  end

  // Digit k is dark when it and every higher nibble are zero and no DP
  always_comb begin
    lz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      lz[k] = (LZ_BLANK != 0)
           && ((val_nx >> (4 * k)) == '0)
           && !dp_nx[k];
    end
  end

  assign nib_nx   = val_nx[{dig_nx, 2'b00} +: 4];
  assign drive_nx = (st_nx == DRIVE) && !lz[dig_nx];
  assign an_nx    = ~(NUM_DIGITS'(1) << dig_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      dig        <= '0;
      cnt        <= '0;
      shd_val    <= '0;
      shd_dp     <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      pend       <= 1'b0;
      hex_out    <= 4'h0;
      seg_out    <= 8'hFF;
      an_out     <= '1;
      frame_sync <= 1'b0;
    end else begin
      st         <= st_nx;
      dig        <= dig_nx;
      cnt        <= cnt_nx;
      act_val    <= val_nx;
      act_dp     <= dp_nx;
      frame_sync <= bound_nx;
      if (load) begin
        shd_val <= value;
        shd_dp  <= dp_mask;
      end
      if (frame_sync)
        pend <= 1'b0;
      else if (load)
        pend <= 1'b1;
      hex_out <= (st_nx == IDLE) ? 4'h0 : nib_nx;
      an_out  <= drive_nx ? an_nx : '1;
      // seg_in decodes the nibble already on hex_out for this digit
      seg_out <= drive_nx ? {~dp_nx[dig_nx], seg_in[6:0]}
                          : 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model, directed
// scenarios plus randomized load/enable/reset traffic.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int CPD   = 8;
  localparam int BL    = 2;
  localparam int SLOT  = BL + CPD;
  localparam int FRAME = N * SLOT;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load;
  logic [15:0]  value;
  logic [3:0]   dp_mask;
  logic [3:0]   hex_out;
  logic [7:0]   seg_in;
  logic [7:0]   seg_out;
  logic [3:0]   an_out;
  logic         frame_sync;

  int checks = 0;
  int errors = 0;

  bit           m_run;
  int           m_t;
  logic [15:0]  m_act;
  logic [15:0]  m_sh;
  logic [3:0]   m_dp;
  logic [3:0]   m_sdp;
  bit           m_pend;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N),
    .CLKS_PER_DIGIT(CPD),
    .BLANK_CLKS(BL),
    .LZ_BLANK(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .load(load),
    .value(value),
    .dp_mask(dp_mask),
    .hex_out(hex_out),
    .seg_in(seg_in),
    .seg_out(seg_out),
    .an_out(an_out),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  always_comb seg_in = dec(hex_out);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_blank(input int k);
    return (k > 0) && ((m_act >> (4 * k)) == 16'h0) && !m_dp[k];
  endfunction

  task automatic model_edge();
    bit fs;
    if (rst) begin
      m_run = 0; m_t = 0; m_act = 0; m_sh = 0;
      m_dp = 0; m_sdp = 0; m_pend = 0;
    end else begin
      fs = m_run && (m_t == 0);
      if (fs && load) begin
        m_act = value; m_dp = dp_mask; m_pend = 0;
      end else if (fs && m_pend) begin
        m_act = m_sh; m_dp = m_sdp; m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end
      if (load) begin
        m_sh = value; m_sdp = dp_mask;
      end
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
  endtask

  task automatic compare();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [7:0] d;
    logic [3:0] e_hex;
    logic       e_fs;
    int slot;
    int off;
    e_an = 4'hF; e_seg = 8'hFF; e_hex = 4'h0; e_fs = 1'b0;
    if (m_run) begin
      slot  = m_t / SLOT;
      off   = m_t % SLOT;
      e_fs  = (m_t == 0);
      e_hex = m_act[4*slot +: 4];
      if (off >= BL && !m_blank(slot)) begin
        d     = dec(e_hex);
        e_an  = ~(4'b0001 << slot);
        e_seg = {~m_dp[slot], d[6:0]};
      end
    end
    chk("an_out", an_out, e_an);
    chk("seg_out", seg_out, e_seg);
    chk("frame_sync", frame_sync, e_fs);
    chk("hex_out", hex_out, e_hex);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_mask = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    bit hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      if (frame_sync) hit = 1;
      else step();
    end
    if (!hit) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_an(input logic [3:0] pat, input string tag);
    bit hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      if (an_out == pat) hit = 1;
      else step();
    end
    if (!hit) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    bit hit;
    logic [15:0] rv;
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    value = 16'h0; dp_mask = 4'h0;
    run(2);
    rst = 1'b0; enable = 1'b1;
    do_load(16'h1234, 4'h0);
    run(100);

    wait_fs("period_a");
    step();
    n = 1; hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      if (frame_sync) hit = 1;
      else begin step(); n++; end
    end
    chk("frame_period", n, FRAME);

    do_load(16'h00A0, 4'h0);
    run(90);
    do_load(16'h0000, 4'h0);
    run(90);
    do_load(16'h0005, 4'b0100);
    run(90);

    wait_fs("mid_frame");
    run(15);
    do_load(16'h1111, 4'h0);
    run(3);
    do_load(16'h2222, 4'h0);
    run(90);

    wait_fs("sync_load");
    do_load(16'h8765, 4'b0010);
    run(45);

    wait_an(4'b1101, "drive_d1");
    run(2);
    enable = 1'b0;
    step();
    chk("dis_an", an_out, 4'hF);
    chk("dis_seg", seg_out, 8'hFF);
    run(5);
    enable = 1'b1;
    step();
    chk("reen_fs", frame_sync, 1'b1);
    run(45);

    do_load(16'h4321, 4'h0);
    run(50);
    wait_an(4'b1011, "drive_d2");
    rst = 1'b1;
    step();
    chk("rst_an", an_out, 4'hF);
    chk("rst_seg", seg_out, 8'hFF);
    chk("rst_hex", hex_out, 4'h0);
    rst = 1'b0;
    run(50);

    for (int i = 0; i < 4000; i++) begin
      load = ($urandom_range(0, 29) == 0);
      rv = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 0) rv[4*k +: 4] = 4'h0;
      value   = rv;
      dp_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 15) == 0) enable = 1'b1;
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
